// File: rtl/module_status_pkg.sv
// Shared types and constants for the module status event capture block.
package module_status_pkg;

    localparam int unsigned STATUS_W        = 4;
    localparam int unsigned STATUS_START    = 0;
    localparam int unsigned STATUS_READY    = 1;
    localparam int unsigned STATUS_DONE     = 2;
    localparam int unsigned STATUS_CONTINUE = 3;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Record widths follow the top-level parameters, so this type is sized
    // through the package defaults and re-declared with the real widths in the top.
    localparam int unsigned DEF_TS_W = 32;
    localparam int unsigned DEF_ID_W = 4;

    typedef struct packed {
        logic [DEF_TS_W-1:0] ts;
        logic [DEF_ID_W-1:0] id;
        logic [STATUS_W-1:0] status;
    } rec_default_t;

    // Pack one module's handshake lines into the 4-bit status word.
    function automatic logic [STATUS_W-1:0] make_status(
        input logic s,
        input logic r,
        input logic d,
        input logic c
    );
        logic [STATUS_W-1:0] v;
        v                  = '0;
        v[STATUS_START]    = s;
        v[STATUS_READY]    = r;
        v[STATUS_DONE]     = d;
        v[STATUS_CONTINUE] = c;
        return v;
    endfunction

endpackage

// File: rtl/status_event_fifo.sv
// Synchronous first-word-fall-through FIFO for captured status records.
module status_event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             r_full;
    logic             w_do_push;
    logic             w_do_pop;
    logic [CNT_W-1:0] w_cnt_nxt;

    // A push into a full FIFO is allowed when the head leaves at the same edge.
    always_comb begin
        w_do_pop  = i_pop && r_valid;
        w_do_push = i_push && (!r_full || w_do_pop);
        w_cnt_nxt = r_cnt + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end

    // Storage, pointers and registered flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != '0);
            r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_valid = r_valid;
    assign o_full  = r_full;

endmodule

// File: rtl/module_status_event_capture.sv
// Timestamps ap_* handshake changes of many HLS modules into one record stream.
module module_status_event_capture
    import module_status_pkg::*;
#(
    parameter int unsigned NUM_MODULES = 10,
    parameter int unsigned TS_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DROP_WIDTH  = 16,
    localparam int unsigned ID_W = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MODULES-1:0] ap_start,
    input  logic [NUM_MODULES-1:0] ap_ready,
    input  logic [NUM_MODULES-1:0] ap_done,
    input  logic [NUM_MODULES-1:0] ap_continue,
    input  logic                   finish,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [TS_WIDTH-1:0]    rec_ts,
    output logic [ID_W-1:0]        rec_id,
    output logic [STATUS_W-1:0]    rec_status,
    output logic [DROP_WIDTH-1:0]  drop_count,
    output logic                   done
);

    localparam int unsigned DSUM_W = DROP_WIDTH + 1;

    typedef struct packed {
        logic [TS_WIDTH-1:0] ts;
        logic [ID_W-1:0]     id;
        logic [STATUS_W-1:0] status;
    } rec_t;

    typedef struct packed {
        logic [TS_WIDTH-1:0] ts;
        logic [STATUS_W-1:0] status;
    } hold_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_done;
    logic [TS_WIDTH-1:0]     r_ts;
    logic [STATUS_W-1:0]     r_last [NUM_MODULES];
    hold_t                   r_hold [NUM_MODULES];
    logic [NUM_MODULES-1:0]  r_pending;
    logic [DROP_WIDTH-1:0]   r_drop;

    logic [STATUS_W-1:0]     w_cur [NUM_MODULES];
    logic [NUM_MODULES-1:0]  w_change;
    logic [NUM_MODULES-1:0]  w_drop;
    logic [NUM_MODULES-1:0]  w_grant;
    logic [NUM_MODULES-1:0]  w_take;
    logic [NUM_MODULES-1:0]  w_pending_nxt;
    logic                    w_found;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_valid;
    rec_t                    w_push_rec;
    rec_t                    w_head;
    logic [DSUM_W-1:0]       w_drop_n;
    logic [DSUM_W-1:0]       w_drop_sum;

    // Fixed-priority pick of the lowest-index pending module.
    always_comb begin
        w_grant    = '0;
        w_found    = 1'b0;
        w_push_rec = '0;
        for (int i = 0; i < int'(NUM_MODULES); i++) begin
            if (r_pending[i] && !w_found) begin
                w_found           = 1'b1;
                w_grant[i]        = 1'b1;
                w_push_rec.ts     = r_hold[i].ts;
                w_push_rec.id     = ID_W'(i);
                w_push_rec.status = r_hold[i].status;
            end
        end
    end

    assign w_pop  = w_valid && rec_ready;
    assign w_push = w_found && (!w_full || w_pop);
    assign w_take = w_grant & {NUM_MODULES{w_push}};

    // Change detection, coalescing and pending-bit update.
    always_comb begin
        w_cur         = '{default: '0};
        w_change      = '0;
        w_drop        = '0;
        w_pending_nxt = r_pending;
        for (int i = 0; i < int'(NUM_MODULES); i++) begin
            w_cur[i]    = make_status(ap_start[i], ap_ready[i], ap_done[i], ap_continue[i]);
            w_change[i] = (r_state == CAPTURE) && (w_cur[i] != r_last[i]);
            w_drop[i]   = w_change[i] && r_pending[i] && !w_take[i];
            if (w_change[i]) begin
                w_pending_nxt[i] = 1'b1;
            end else if (w_take[i]) begin
                w_pending_nxt[i] = 1'b0;
            end
        end
    end

    // Several modules can coalesce at one edge; the counter saturates.
    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < int'(NUM_MODULES); i++) begin
            w_drop_n = w_drop_n + DSUM_W'(w_drop[i]);
        end
        w_drop_sum = DSUM_W'(r_drop) + w_drop_n;
    end

    // Timestamp counter, per-module status history and hold registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ts      <= '0;
            r_pending <= '0;
            r_drop    <= '0;
            for (int i = 0; i < int'(NUM_MODULES); i++) begin
                r_last[i] <= '0;
                r_hold[i] <= '0;
            end
        end else begin
            r_ts      <= r_ts + TS_WIDTH'(1);
            r_pending <= w_pending_nxt;
            r_drop    <= w_drop_sum[DROP_WIDTH] ? '1 : w_drop_sum[DROP_WIDTH-1:0];
            for (int i = 0; i < int'(NUM_MODULES); i++) begin
                if (w_change[i]) begin
                    r_last[i]        <= w_cur[i];
                    r_hold[i].ts     <= r_ts;
                    r_hold[i].status <= w_cur[i];
                end
            end
        end
    end

    // Run-phase next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CAPTURE: if (finish) w_state_nxt = DRAIN;
            DRAIN:   if ((r_pending == '0) && !w_valid) w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = CAPTURE;
        endcase
    end

    // Run-phase state register and done flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= CAPTURE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_state_nxt == DONE);
        end
    end

    status_event_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  (w_push_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (w_valid),
        .o_full  (w_full)
    );

    assign rec_valid  = w_valid;
    assign rec_ts     = w_head.ts;
    assign rec_id     = w_head.id;
    assign rec_status = w_head.status;
    assign drop_count = r_drop;
    assign done       = r_done;

endmodule

// File: tb/tb_module_status_event_capture.sv
// Directed scoreboard bench for module_status_event_capture.
`timescale 1ns/1ps
module tb_module_status_event_capture;

    localparam int unsigned NM = 10;

    typedef struct packed {
        logic [31:0] ts;
        logic [3:0]  id;
        logic [3:0]  status;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rst_w = 1'b1;
    logic [NM-1:0] ap_start = '0;
    logic [NM-1:0] ap_ready = '0;
    logic [NM-1:0] ap_done = '0;
    logic [NM-1:0] ap_continue = '0;
    logic          finish = 1'b0;
    logic          rec_ready = 1'b0;
    logic          rec_valid;
    logic [31:0]   rec_ts;
    logic [3:0]    rec_id;
    logic [3:0]    rec_status;
    logic [15:0]   drop_count;
    logic          done;

    logic [1:0]    w_start = '0;
    logic          w_valid;
    logic [3:0]    w_ts;
    logic [0:0]    w_id;
    logic [3:0]    w_status;
    logic [3:0]    w_drop;
    logic          w_done;

    int            n_vec = 0;
    int            n_err = 0;
    int unsigned   tb_ts;
    exp_t          q_main[$];
    exp_t          q_w[$];
    exp_t          m_e;
    exp_t          n_e;

    always #5 clock = ~clock;

    module_status_event_capture u_dut (
        .clock       (clock),
        .reset       (reset),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .finish      (finish),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_ts      (rec_ts),
        .rec_id      (rec_id),
        .rec_status  (rec_status),
        .drop_count  (drop_count),
        .done        (done)
    );

    module_status_event_capture #(
        .NUM_MODULES (2),
        .TS_WIDTH    (4),
        .FIFO_DEPTH  (4),
        .DROP_WIDTH  (4)
    ) u_narrow (
        .clock       (clock),
        .reset       (rst_w),
        .ap_start    (w_start),
        .ap_ready    (2'b00),
        .ap_done     (2'b00),
        .ap_continue (2'b00),
        .finish      (1'b0),
        .rec_valid   (w_valid),
        .rec_ready   (1'b1),
        .rec_ts      (w_ts),
        .rec_id      (w_id),
        .rec_status  (w_status),
        .drop_count  (w_drop),
        .done        (w_done)
    );

    // Reference cycle count: the timestamp the next rising edge will sample.
    always @(posedge clock or negedge reset) begin
        if (!reset) tb_ts <= 0;
        else        tb_ts <= tb_ts + 1;
    end

    // Main-instance monitor: every accepted record must match the queue head.
    always @(negedge clock) begin
        if (reset && rec_valid && rec_ready) begin
            n_vec++;
            if (q_main.size() == 0) begin
                n_err++;
                $display("FAIL main_unexpected: got ts=%0d id=%0d st=%b, expected no record",
                         rec_ts, rec_id, rec_status);
            end else begin
                m_e = q_main.pop_front();
                if ({rec_ts, rec_id, rec_status} !== {m_e.ts, m_e.id, m_e.status}) begin
                    n_err++;
                    $display("FAIL main_record: got ts=%0d id=%0d st=%b, expected ts=%0d id=%0d st=%b",
                             rec_ts, rec_id, rec_status, m_e.ts, m_e.id, m_e.status);
                end
            end
        end
    end

    // Narrow-instance monitor (consumer always ready).
    always @(negedge clock) begin
        if (rst_w && w_valid) begin
            n_vec++;
            if (q_w.size() == 0) begin
                n_err++;
                $display("FAIL narrow_unexpected: got ts=%0d id=%0d st=%b, expected no record",
                         w_ts, w_id, w_status);
            end else begin
                n_e = q_w.pop_front();
                if ({28'd0, w_ts, 3'd0, w_id, w_status} !== {n_e.ts, n_e.id, n_e.status}) begin
                    n_err++;
                    $display("FAIL narrow_record: got ts=%0d id=%0d st=%b, expected ts=%0d id=%0d st=%b",
                             w_ts, w_id, w_status, n_e.ts, n_e.id, n_e.status);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout, expected event within bound", name);
    endtask

    task automatic expm(input int unsigned t, input int unsigned id, input logic [3:0] st);
        q_main.push_back('{ts: 32'(t), id: 4'(id), status: st});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ts(input int unsigned t);
        int n;
        n = 0;
        while (tb_ts != t && n < 300) begin
            tick();
            n++;
        end
        if (tb_ts != t) fail_bound("wait_ts");
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q_main.size() != 0 || rec_valid) && n < 200) begin
            tick();
            n++;
        end
        if (q_main.size() != 0 || rec_valid) fail_bound("drain");
    endtask

    // Clears the monitored inputs, pulses reset, releases it between edges.
    task automatic do_reset();
        ap_start    = '0;
        ap_ready    = '0;
        ap_done     = '0;
        ap_continue = '0;
        finish      = 1'b0;
        reset       = 1'b0;
        tick();
        tick();
        #3 reset = 1'b1;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        rst_w = 1'b0;
        #1;
        chk("rst_valid",  64'(rec_valid),  64'(0));
        chk("rst_ts",     64'(rec_ts),     64'(0));
        chk("rst_id",     64'(rec_id),     64'(0));
        chk("rst_status", 64'(rec_status), 64'(0));
        chk("rst_drop",   64'(drop_count), 64'(0));
        chk("rst_done",   64'(done),       64'(0));
        chk("rst_nvalid", 64'(w_valid),    64'(0));

        // ap_ready[2] pulse
        do_reset();
        rec_ready = 1'b1;
        wait_ts(5);
        ap_ready[2] = 1'b1;
        expm(5, 2, 4'b0010);
        tick();
        ap_ready[2] = 1'b0;
        expm(6, 2, 4'b0000);
        wait_drain();
        chk("pulse_drop", 64'(drop_count), 64'(0));

        // simultaneous changes leave in id order
        wait_ts(10);
        ap_start[0] = 1'b1;
        ap_start[3] = 1'b1;
        ap_start[7] = 1'b1;
        expm(10, 0, 4'b0001);
        expm(10, 3, 4'b0001);
        expm(10, 7, 4'b0001);
        wait_drain();

        // back-pressure, FIFO full and coalescing
        do_reset();
        rec_ready = 1'b0;
        wait_ts(2);
        for (int k = 0; k < 20; k++) begin
            ap_done[1] = (k % 2 == 0);
            tick();
        end
        for (int t = 2; t <= 17; t++) begin
            expm(t, 1, (t % 2 == 0) ? 4'b0100 : 4'b0000);
        end
        expm(21, 1, 4'b0000);
        chk("full_drop",   64'(drop_count), 64'(3));
        chk("hold_valid",  64'(rec_valid),  64'(1));
        chk("hold_ts0",    64'(rec_ts),     64'(2));
        tick();
        chk("hold_ts1",    64'(rec_ts),     64'(2));
        chk("hold_status", 64'(rec_status), 64'(4'b0100));
        rec_ready = 1'b1;
        wait_drain();
        chk("full_drop_after", 64'(drop_count), 64'(3));

        // reset while records are queued
        rec_ready = 1'b0;
        ap_start[4:0] = 5'b11111;
        repeat (8) tick();
        chk("pre_rst_valid", 64'(rec_valid),  64'(1));
        chk("pre_rst_drop",  64'(drop_count), 64'(3));
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(rec_valid),  64'(0));
        chk("mid_rst_drop",  64'(drop_count), 64'(0));
        chk("mid_rst_ts",    64'(rec_ts),     64'(0));
        tick();
        #3 reset = 1'b1;
        rec_ready = 1'b1;
        for (int i = 0; i < 5; i++) expm(0, i, 4'b0001);
        tick();
        wait_drain();

        // finish with records queued
        do_reset();
        rec_ready = 1'b0;
        wait_ts(3);
        ap_start[7:4] = 4'hF;
        for (int i = 4; i < 8; i++) expm(3, i, 4'b0001);
        wait_ts(8);
        chk("fin_valid", 64'(rec_valid), 64'(1));
        chk("fin_done0", 64'(done),      64'(0));
        finish    = 1'b1;
        rec_ready = 1'b1;
        tick();
        ap_start[0] = 1'b1;
        tick();
        chk("fin_done1", 64'(done), 64'(0));
        begin
            int n;
            n = 0;
            while (!done && n < 20) begin
                tick();
                n++;
            end
            if (!done) fail_bound("done_rise");
        end
        chk("fin_queue", 64'(q_main.size()), 64'(0));
        ap_start[1]    = 1'b1;
        ap_continue[2] = 1'b1;
        repeat (5) tick();
        chk("done_quiet", 64'(rec_valid), 64'(0));
        chk("done_held",  64'(done),      64'(1));

        // 4-bit timestamp wrap on the narrow instance
        #3 rst_w = 1'b1;
        tick();
        repeat (14) tick();
        w_start[1] = 1'b1;
        q_w.push_back('{ts: 32'd15, id: 4'd1, status: 4'b0001});
        tick();
        tick();
        w_start[1] = 1'b0;
        q_w.push_back('{ts: 32'd1, id: 4'd1, status: 4'b0000});
        begin
            int n;
            n = 0;
            while ((q_w.size() != 0 || w_valid) && n < 20) begin
                tick();
                n++;
            end
            if (q_w.size() != 0) fail_bound("narrow_drain");
        end
        chk("narrow_drop", 64'(w_drop), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
